ad9854_sweep_writer: RTL and testbench

Parametrised parallel-port write engine for the AD9854 DDS.
- Loads a 48-bit frequency tuning word (FTW) into the device byte-by-byte over A/D/WR, then pulses UDCLK.
- Optionally runs autonomous sweeps between f_start and f_stop in steps of f_step, with a programmable dwell between steps.
- Sits between the key/control logic in top-level and the DDS pins; supersedes the fixed single-word driver.

---
 rtl/ad9854_pkg.sv | 30 +++
 rtl/ad9854_bus_writer.sv | 77 +++++++
 rtl/ad9854_sweep_writer.sv | 171 +++++++++++++++++
 tb/tb_ad9854_sweep_writer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9854_pkg.sv
// ad9854_pkg: register map, run modes and FSM encodings shared by the AD9854 write engine.
package ad9854_pkg;

    localparam logic [5:0] ADDR_FTW1 = 6'h04;
    localparam logic [5:0] ADDR_FTW2 = 6'h0A;
    localparam logic [5:0] ADDR_DFW  = 6'h10;
    localparam logic [5:0] ADDR_CTRL = 6'h1D;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_ONCE   = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD   = 3'd1;
    localparam state_t S_WRITE  = 3'd2;
    localparam state_t S_UPDATE = 3'd3;
    localparam state_t S_DWELL  = 3'd4;
    localparam state_t S_STEP   = 3'd5;

    typedef logic [1:0] bw_state_t;
    localparam bw_state_t BW_IDLE   = 2'd0;
    localparam bw_state_t BW_SETUP  = 2'd1;
    localparam bw_state_t BW_STROBE = 2'd2;
    localparam bw_state_t BW_HOLD   = 2'd3;

endpackage

// File: rtl/ad9854_bus_writer.sv
// ad9854_bus_writer: one parallel-port byte write (SETUP, WR low, WR high); ack in the last high cycle.
module ad9854_bus_writer
    import ad9854_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] a_o,
    output logic [DATA_W-1:0] d_o,
    output logic              wr_o,
    output logic              ack_o
);
    localparam int CW = $clog2((WR_LOW > WR_HIGH ? WR_LOW : WR_HIGH) + 1);

    bw_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              wr_q, wr_d, take;

    assign ack_o = state_q == BW_HOLD && cnt_q == CW'(WR_HIGH - 1);
    // A queued request chains straight into the next SETUP so bytes run back to back.
    assign take  = req_i && !abort_i && (state_q == BW_IDLE || ack_o);
    assign a_o   = a_q;
    assign d_o   = d_q;
    assign wr_o  = wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        a_d     = take ? addr_i : a_q;
        d_d     = take ? data_i : d_q;
        case (state_q)
            BW_SETUP: begin
                state_d = BW_STROBE;
                cnt_d   = '0;
            end
            BW_STROBE: if (cnt_q == CW'(WR_LOW - 1)) begin
                state_d = BW_HOLD;
                cnt_d   = '0;
            end
            BW_HOLD: state_d = ack_o ? BW_IDLE : BW_HOLD;
            default: state_d = BW_IDLE;
        endcase
        if (take) begin
            state_d = BW_SETUP;
            cnt_d   = '0;
        end
        if (abort_i) state_d = BW_IDLE;
        wr_d = state_d != BW_STROBE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BW_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            wr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            d_q     <= d_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: rtl/ad9854_sweep_writer.sv
// ad9854_sweep_writer: loads FTWs into the AD9854 byte by byte with UDCLK, optionally sweeping f_start..f_stop.
module ad9854_sweep_writer
    import ad9854_pkg::*;
#(
    parameter int                FTW_W    = 48,
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] FTW_ADDR = ADDR_W'(ADDR_FTW1),
    parameter int                WR_LOW   = 2,
    parameter int                WR_HIGH  = 2,
    parameter int                UD_W     = 4,
    parameter int                DWELL_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         mode_i,
    input  logic [FTW_W-1:0]   f_start_i,
    input  logic [FTW_W-1:0]   f_stop_i,
    input  logic [FTW_W-1:0]   f_step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [ADDR_W-1:0]  a_o,
    output logic [DATA_W-1:0]  d_o,
    output logic               wr_o,
    output logic               rd_o,
    output logic               udclk_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [FTW_W-1:0]   cur_ftw_o
);
    localparam int NB    = FTW_W / DATA_W;
    localparam int IW    = NB > 1 ? $clog2(NB) : 1;
    localparam int CNT_W = DWELL_W > 8 ? DWELL_W : 8;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [FTW_W-1:0]   lo_q, lo_d, hi_q, hi_d, step_q, step_d, cur_q, cur_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d, done_q, done_d;
    logic               ack, req, last_byte, single, at_end;
    logic [FTW_W:0]     sum, diff;
    logic [FTW_W-1:0]   up_next, dn_next, ftw_sh;
    logic [ADDR_W-1:0]  byte_addr;

    assign last_byte = idx_q == IW'(NB - 1);
    assign req       = state_q == S_WRITE && !(ack && last_byte);
    // Address and data follow the index being handed to the writer, so a chained byte sees its own values.
    assign ftw_sh    = cur_q << (DATA_W * int'(idx_d));
    assign byte_addr = FTW_ADDR + ADDR_W'(idx_d);
    assign sum       = {1'b0, cur_q} + {1'b0, step_q};
    assign diff      = {1'b0, cur_q} - {1'b0, step_q};
    assign up_next   = (sum[FTW_W] || sum[FTW_W-1:0] > hi_q) ? hi_q : sum[FTW_W-1:0];
    assign dn_next   = (diff[FTW_W] || diff[FTW_W-1:0] < lo_q) ? lo_q : diff[FTW_W-1:0];
    assign single    = mode_q == MODE_SINGLE || step_q == '0 || lo_q >= hi_q;
    assign at_end    = dir_q ? cur_q == lo_q : cur_q == hi_q;

    assign rd_o      = 1'b1;
    assign udclk_o   = state_q == S_UPDATE;
    assign busy_o    = state_q != S_IDLE;
    assign done_o    = done_q;
    assign cur_ftw_o = cur_q;

    ad9854_bus_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WR_LOW (WR_LOW),
        .WR_HIGH(WR_HIGH)
    ) u_bus (
        .clk    (clk),
        .rst    (rst),
        .abort_i(abort_i),
        .req_i  (req),
        .addr_i (byte_addr),
        .data_i (ftw_sh[FTW_W-1 -: DATA_W]),
        .a_o    (a_o),
        .d_o    (d_o),
        .wr_o   (wr_o),
        .ack_o  (ack)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        idx_d   = ack ? idx_q + IW'(1) : idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_LOAD;
                mode_d  = mode_t'(mode_i);
                lo_d    = f_start_i;
                hi_d    = f_stop_i;
                step_d  = f_step_i;
                dwell_d = dwell_i;
            end
            S_LOAD: begin
                state_d = S_WRITE;
                cur_d   = lo_q;
                dir_d   = 1'b0;
                idx_d   = '0;
            end
            S_WRITE: if (ack && last_byte) begin
                state_d = S_UPDATE;
                cnt_d   = '0;
            end
            S_UPDATE: if (cnt_q == CNT_W'(UD_W - 1)) begin
                state_d = dwell_q == '0 ? S_STEP : S_DWELL;
                cnt_d   = '0;
            end
            S_DWELL: state_d = cnt_q == CNT_W'(dwell_q) - CNT_W'(1) ? S_STEP : S_DWELL;
            S_STEP: begin
                state_d = S_WRITE;
                idx_d   = '0;
                if (single || (at_end && mode_q == MODE_ONCE)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (at_end && mode_q == MODE_SAW) begin
                    cur_d = lo_q;
                end else if (at_end) begin
                    dir_d = !dir_q;
                    cur_d = dir_q ? up_next : dn_next;
                end else begin
                    cur_d = dir_q ? dn_next : up_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_SINGLE;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cur_q   <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ad9854_sweep_writer.sv
// tb_ad9854_sweep_writer: scoreboard bench; expected words are queued at start and popped on each UDCLK rise.
module tb_ad9854_sweep_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [47:0] f_start_i = '0;
    logic [47:0] f_stop_i = '0;
    logic [47:0] f_step_i = '0;
    logic [15:0] dwell_i = '0;
    logic [5:0]  a_o;
    logic [7:0]  d_o;
    logic        wr_o, rd_o, udclk_o, busy_o, done_o;
    logic [47:0] cur_ftw_o;

    ad9854_sweep_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .mode_i   (mode_i),
        .f_start_i(f_start_i),
        .f_stop_i (f_stop_i),
        .f_step_i (f_step_i),
        .dwell_i  (dwell_i),
        .a_o      (a_o),
        .d_o      (d_o),
        .wr_o     (wr_o),
        .rd_o     (rd_o),
        .udclk_o  (udclk_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .cur_ftw_o(cur_ftw_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_wr_cyc = 0;
    int          ud_pulses = 0;
    int          done_pulses = 0;
    int          nbytes = 0;
    int          wr_low_n = 0;
    int          ud_n = 0;
    logic        prev_wr = 1'b1;
    logic        prev_ud = 1'b0;
    logic        prev_done = 1'b0;
    logic [5:0]  cap_a = '0;
    logic [7:0]  cap_d = '0;
    logic [5:0]  addrs [6];
    logic [7:0]  bytes [6];
    logic [47:0] exp_q [$];

    // One clock step: sample outputs 1 time unit after the edge and run the bus monitor.
    task automatic tick();
        logic [47:0] word, e;
        logic        ok;
        @(posedge clk);
        #1;
        cyc++;
        if (!busy_o) nbytes = 0;
        if (!wr_o) wr_low_n++;
        if (prev_wr && !wr_o) begin
            cap_a = a_o;
            cap_d = d_o;
            if (nbytes == 0) first_wr_cyc = cyc;
        end
        if (!prev_wr && wr_o && busy_o) begin
            vectors++;
            if (wr_low_n != 2) begin
                miscompares++;
                $display("FAIL wr_low_width: got %0d cycles, want 2", wr_low_n);
            end
            if (nbytes < 6) begin
                bytes[nbytes] = cap_d;
                addrs[nbytes] = cap_a;
            end
            nbytes++;
        end
        if (wr_o) wr_low_n = 0;
        if (udclk_o) ud_n++;
        if (!prev_ud && udclk_o) begin
            ud_pulses++;
            ok = nbytes == 6 && rd_o === 1'b1;
            for (int i = 0; i < 6 && ok; i++) ok = addrs[i] == 6'(6'h04 + i);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL bus_framing: got %0d bytes first addr %h rd %b, want 6 bytes at 04..09 rd 1", nbytes, addrs[0], rd_o);
            end
            word = {bytes[0], bytes[1], bytes[2], bytes[3], bytes[4], bytes[5]};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got %h, want no update", word);
            end else begin
                e = exp_q.pop_front();
                if (word !== e || cur_ftw_o !== e) begin
                    miscompares++;
                    $display("FAIL word: bus %h cur_ftw %h, want %h", word, cur_ftw_o, e);
                end
            end
            nbytes = 0;
        end
        if (prev_ud && !udclk_o) begin
            vectors++;
            if (ud_n != 4) begin
                miscompares++;
                $display("FAIL udclk_width: got %0d cycles, want 4", ud_n);
            end
        end
        if (!udclk_o) ud_n = 0;
        if (done_o) begin
            done_pulses++;
            vectors++;
            if (busy_o !== 1'b0 || prev_done) begin
                miscompares++;
                $display("FAIL done_pulse: busy %b prev_done %b, want busy 0 and 1-cycle pulse", busy_o, prev_done);
            end
        end
        prev_wr   = wr_o;
        prev_ud   = udclk_o;
        prev_done = done_o;
    endtask

    task automatic go(input logic [1:0] m, input logic [47:0] fs, input logic [47:0] fe,
                      input logic [47:0] st, input logic [15:0] dw);
        mode_i    = m;
        f_start_i = fs;
        f_stop_i  = fe;
        f_step_i  = st;
        dwell_i   = dw;
        start_i   = 1'b1;
        tick();
        start_cyc = cyc;
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_pulses;
        for (int i = 0; i < budget && done_pulses == d0; i++) tick();
        vectors++;
        if (done_pulses == d0) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({a_o, d_o, wr_o, rd_o, udclk_o, busy_o, done_o, cur_ftw_o} !== {6'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0}) begin
            miscompares++;
            $display("FAIL reset_values: A %h D %h WR %b RD %b UD %b busy %b done %b cur %h, want 0 0 1 1 0 0 0 0",
                     a_o, d_o, wr_o, rd_o, udclk_o, busy_o, done_o, cur_ftw_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int u0 = ud_pulses;
        exp_q.push_back(48'h0147_AE14_7AE1);
        go(2'd0, 48'h0147_AE14_7AE1, 48'd0, 48'd0, 16'd0);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: got %b, want 1 after start", busy_o);
        end
        wait_done(100, "single");
        vectors++;
        if (first_wr_cyc - start_cyc != 3) begin
            miscompares++;
            $display("FAIL first_wr_latency: got %0d, want 3", first_wr_cyc - start_cyc);
        end
        vectors++;
        if (exp_q.size() != 0 || ud_pulses - u0 != 1 || cur_ftw_o !== 48'h0147_AE14_7AE1) begin
            miscompares++;
            $display("FAIL single_summary: left %0d pulses %0d cur %h, want 0 1 0147ae147ae1", exp_q.size(), ud_pulses - u0, cur_ftw_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_sweep_once();
        int u0 = ud_pulses;
        exp_q.push_back(48'd100);
        exp_q.push_back(48'd200);
        exp_q.push_back(48'd300);
        exp_q.push_back(48'd350);
        go(2'd1, 48'd100, 48'd350, 48'd100, 16'd3);
        wait_done(1000, "sweep_once");
        vectors++;
        if (exp_q.size() != 0 || ud_pulses - u0 != 4 || cur_ftw_o !== 48'd350) begin
            miscompares++;
            $display("FAIL sweep_once_summary: left %0d pulses %0d cur %0d, want 0 4 350", exp_q.size(), ud_pulses - u0, cur_ftw_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_triangle_abort();
        int u0 = ud_pulses;
        int d0 = done_pulses;
        bit hit = 1'b0;
        exp_q.push_back(48'd10);
        exp_q.push_back(48'd20);
        exp_q.push_back(48'd30);
        exp_q.push_back(48'd20);
        exp_q.push_back(48'd10);
        exp_q.push_back(48'd20);
        go(2'd3, 48'd10, 48'd30, 48'd10, 16'd0);
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            hit = ud_pulses - u0 == 5 && nbytes == 3;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL triangle_reach_word6: pulses %0d bytes %0d, want 5 and 3", ud_pulses - u0, nbytes);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        vectors++;
        if (wr_o !== 1'b1 || busy_o !== 1'b0 || udclk_o !== 1'b0 || cur_ftw_o !== 48'd20) begin
            miscompares++;
            $display("FAIL abort_outputs: WR %b busy %b UD %b cur %0d, want 1 0 0 20", wr_o, busy_o, udclk_o, cur_ftw_o);
        end
        repeat (20) tick();
        vectors++;
        if (done_pulses != d0 || exp_q.size() != 1) begin
            miscompares++;
            $display("FAIL abort_aftermath: done pulses %0d left %0d, want 0 1", done_pulses - d0, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int u0 = ud_pulses;
        int d0 = done_pulses;
        bit hit = 1'b0;
        exp_q.push_back(48'd0);
        exp_q.push_back(48'd5);
        exp_q.push_back(48'd10);
        exp_q.push_back(48'd0);
        exp_q.push_back(48'd5);
        go(2'd2, 48'd0, 48'd10, 48'd5, 16'd0);
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (i % 7 == 3) begin
                mode_i    = 2'd0;
                f_start_i = 48'hABC;
                start_i   = 1'b1;
            end
            tick();
            start_i = 1'b0;
            hit = ud_pulses - u0 == 5 && !udclk_o;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL sawtooth_reach: pulses %0d, want 5", ud_pulses - u0);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        repeat (5) tick();
        vectors++;
        if (busy_o !== 1'b0 || exp_q.size() != 0 || done_pulses != d0) begin
            miscompares++;
            $display("FAIL sawtooth_summary: busy %b left %0d done %0d, want 0 0 0", busy_o, exp_q.size(), done_pulses - d0);
        end
        exp_q.delete();
    endtask

    task automatic test_degenerate();
        int u0 = ud_pulses;
        exp_q.push_back(48'd77);
        go(2'd1, 48'd77, 48'd500, 48'd0, 16'd2);
        wait_done(200, "step_zero");
        vectors++;
        if (exp_q.size() != 0 || ud_pulses - u0 != 1) begin
            miscompares++;
            $display("FAIL step_zero_summary: left %0d pulses %0d, want 0 1", exp_q.size(), ud_pulses - u0);
        end
        repeat (2) tick();
        u0 = ud_pulses;
        exp_q.push_back(48'd50);
        go(2'd1, 48'd50, 48'd40, 48'd5, 16'd0);
        wait_done(200, "start_above_stop");
        vectors++;
        if (exp_q.size() != 0 || ud_pulses - u0 != 1 || cur_ftw_o !== 48'd50) begin
            miscompares++;
            $display("FAIL start_above_stop_summary: left %0d pulses %0d cur %0d, want 0 1 50", exp_q.size(), ud_pulses - u0, cur_ftw_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        exp_q.push_back(48'h1234_5678_9ABC);
        go(2'd0, 48'h1234_5678_9ABC, 48'd0, 48'd0, 16'd0);
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            hit = wr_o === 1'b0;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_strobe: WR never low, got %b want 0", wr_o);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({a_o, d_o, wr_o, rd_o, udclk_o, busy_o, done_o, cur_ftw_o} !== {6'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_values: A %h D %h WR %b RD %b UD %b busy %b done %b cur %h, want 0 0 1 1 0 0 0 0",
                     a_o, d_o, wr_o, rd_o, udclk_o, busy_o, done_o, cur_ftw_o);
        end
        rst = 1'b0;
        exp_q.delete();
        tick();
        exp_q.push_back(48'hFEDC_BA98_7654);
        go(2'd0, 48'hFEDC_BA98_7654, 48'd0, 48'd0, 16'd0);
        wait_done(100, "after_reset");
        vectors++;
        if (exp_q.size() != 0 || cur_ftw_o !== 48'hFEDC_BA98_7654) begin
            miscompares++;
            $display("FAIL after_reset_summary: left %0d cur %h, want 0 fedcba987654", exp_q.size(), cur_ftw_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep_once();
        test_triangle_abort();
        test_back_to_back();
        test_degenerate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
